// File: rtl/norm_seq_ctrl.sv
// norm_seq_ctrl: sequencer for one norm datapath instance.
// It clears norm, streams `len` samples in with a valid/ready handshake,
// then issues one divide per element and hands each normalised result
// downstream, honouring backpressure.
module norm_seq_ctrl #(
    parameter int bw  = 4,
    parameter int len = 8,
    parameter int cw  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [bw-1:0]   in_data,
    output logic            in_ready,
    output logic            norm_reset,
    output logic            norm_wr,
    output logic            norm_div,
    output logic [bw-1:0]   norm_in,
    input  logic            norm_full,
    input  logic [2*bw-1:0] norm_out,
    output logic            out_valid,
    output logic [2*bw-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        DIVIDE = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    localparam logic [cw-1:0] len_c    = cw'(len);
    localparam logic [cw-1:0] last_idx = cw'(len - 1);

    state_t          state;
    logic [cw-1:0]   wr_cnt;
    logic [cw-1:0]   rd_cnt;
    logic [cw-1:0]   res_idx;
    logic            nz_flag;
    logic            out_valid_reg;
    logic            done_reg;
    logic            accept;
    logic            handshake;

    // Handshake-level strobes are combinational so a write or divide lands
    // in the same cycle as the condition that allows it.
    always_comb begin
        in_ready   = (state == ACCUM) & ~norm_full;
        accept     = in_ready & in_valid;
        norm_wr    = accept;
        norm_div   = (state == DIVIDE) & (rd_cnt < len_c) & (~out_valid_reg | out_ready);
        handshake  = out_valid_reg & out_ready;
        norm_reset = ~reset | (state == CLEAR);
        norm_in    = in_data;
        busy       = (state != IDLE);
        out_valid  = out_valid_reg;
        // res_idx is the index of the divide that produced the current result.
        out_last   = out_valid_reg & (res_idx == last_idx);
        // An all-zero vector divides by a zero sum; the popped value is junk.
        out_data   = nz_flag ? norm_out : '0;
        done       = done_reg;
    end

    // Sequencer state, element counters and the result-valid pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            res_idx       <= '0;
            nz_flag       <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // norm.out appears one cycle after div, so valid follows div.
            if (norm_div) begin
                out_valid_reg <= 1'b1;
                res_idx       <= rd_cnt;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        nz_flag <= nz_flag | (in_data != '0);
                        if (wr_cnt == last_idx) begin
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                            state  <= DIVIDE;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (norm_div) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (handshake && out_last) begin
                        done_reg <= 1'b1;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    nz_flag <= 1'b0;
                    wr_cnt  <= '0;
                    rd_cnt  <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
